cpu_bus_ram_target: RTL and testbench
=====================================

// Module: cpu_bus_ram_target
// PURPOSE
//  Bus responder (target) for the CPU-side request/ready bus used by the instruction cache and other initiators.
//  Accepts one read or write per handshake, holds it for a programmable number of wait states, then answers with a single-cycle o_ready.
//  Backed by an internal word-addressed RAM.
//  Sits behind the bus interconnect as a simple main-memory / boot-RAM model, synthesizable to block RAM.
// PARAMETERS
//  SIZE         1024  number of 32-bit words in RAM (power of two)
//  ADDR_LSH     2     address bits dropped before indexing (byte address -> word index)
//  WAIT_STATES  1     extra cycles between accept and response (0..15)
// PORTS
//  i_clock      in   1   system clock; all logic on posedge
//  i_reset      in   1   synchronous, active-high reset
//  i_request    in   1   initiator request; held high until o_ready seen
//  i_rw         in   1   0 = read, 1 = write
//  i_address    in   32  byte address
//  i_wdata      in   32  write data
//  o_rdata      out  32  read data; valid while o_ready=1
//  o_ready      out  1   single-cycle completion strobe (registered)
// BEHAVIOUR
//  Interface: one clock (i_clock); reset i_reset is synchronous, active-high.
//  Reset: state<=IDLE, o_ready<=0, o_rdata<=0, wait counter<=0.
//   RAM contents are not cleared by reset.
//  Index: idx = i_address[ADDR_LSH +: log2(SIZE)]; upper address bits ignored, so addresses alias modulo SIZE words.
//  FSM: IDLE, WAIT, RESPOND.
//   IDLE: if i_request=1 at posedge, latch address/rw/wdata, counter<=WAIT_STATES.
//    Then go to WAIT if WAIT_STATES>0; otherwise perform the access and go to RESPOND.
//   WAIT: if i_request=0 at posedge -> abort to IDLE: no access, no o_ready.
//    Else if counter>1 then counter<=counter-1.
//    Else (counter=1): perform the access -> RESPOND.
//   RESPOND: o_ready=1 for exactly this cycle; next state IDLE unconditionally.
//    i_request still high in this cycle is the tail of the finished transaction, never a new one.
//  Access (at the posedge entering RESPOND):
//   write: mem[idx]<=latched wdata; o_rdata unchanged.
//   read: o_rdata<=mem[idx] (latched idx).
//  Latency: request first high in IDLE in cycle N -> o_ready high in cycle N+1+WAIT_STATES.
//  Throughput: minimum handshake period is WAIT_STATES+2 cycles.
//  Latched fields: i_address, i_rw and i_wdata changes after acceptance are ignored.
//  o_rdata holds its last read value when o_ready=0; initiators must sample only while o_ready=1.
//  Back-to-back: the initiator may keep i_request high through the o_ready cycle and the cycle after.
//   That request is accepted in the IDLE cycle following RESPOND.
//  Reset mid-operation: pending transaction dropped; no write performed unless the access edge already occurred.
//   o_ready=0 the following cycle.
//  Simultaneous reset and request: reset wins; request not accepted.
// TESTING
//  T1 reset: assert i_reset 2 cycles with i_request=1 -> o_ready=0, o_rdata=0, no access.
//  T2 write/read, WAIT_STATES=2: write 0xDEADBEEF @0x10, req in cycle 0 -> o_ready only in cycle 3.
//   Then read @0x10 -> o_ready 3 cycles after accept, o_rdata=0xDEADBEEF.
//  T3 icache-style back-to-back: WAIT_STATES=2, reads @0x0 then @0x4 with request held high.
//   -> o_ready in cycles 3 and 7 exactly, correct data each, never two-cycle ready.
//  T4 latch check: read @0x10 accepted, i_address switched to 0x20 in WAIT -> data of 0x10 returned.
//  T5 abort: write 0x12345678 @0x8, drop i_request in cycle 1 (WAIT_STATES=2).
//   -> no o_ready; subsequent read @0x8 returns old value.
//  T6 alias/zero-wait: SIZE=1024, WAIT_STATES=0: write 0xA5A5A5A5 @0x1000, read @0x0.
//   -> 0xA5A5A5A5, o_ready in cycle after accept.
//   Also reset asserted in WAIT -> no o_ready, FSM back in IDLE.

Source files
------------

// File: rtl/cpu_bus_ram_target.sv
// Request/ready bus target backed by a word-addressed block RAM.
// Each accepted access is held for WAIT_STATES cycles, then answered with a one-cycle o_ready.
module cpu_bus_ram_target #(
    parameter int SIZE        = 1024,
    parameter int ADDR_LSH    = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready
);
    localparam int IDX_W = $clog2(SIZE);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t             state_reg;
    logic [3:0]         count_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               rw_reg;
    logic [31:0]        wdata_reg;
    logic               ready_reg;
    logic [31:0]        rdata_reg;

    logic [31:0]        mem [SIZE];

    logic [IDX_W-1:0]   req_idx;
    logic               access_en;
    logic               access_we;
    logic [IDX_W-1:0]   access_idx;
    logic [31:0]        access_wdata;
    logic               addr_unused;

    // Upper address bits alias; only the word index field is decoded.
    assign req_idx     = i_address[ADDR_LSH +: IDX_W];
    assign addr_unused = ^i_address;

    // With zero wait states the access happens on the accept edge using live inputs.
    always_comb begin
        access_en    = 1'b0;
        access_we    = rw_reg;
        access_idx   = idx_reg;
        access_wdata = wdata_reg;
        if (!i_reset && i_request) begin
            if (state_reg == S_IDLE && WAIT_STATES == 0) begin
                access_en    = 1'b1;
                access_we    = i_rw;
                access_idx   = req_idx;
                access_wdata = i_wdata;
            end else if (state_reg == S_WAIT && count_reg <= 4'd1) begin
                access_en    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_request) begin
                        idx_reg   <= req_idx;
                        rw_reg    <= i_rw;
                        wdata_reg <= i_wdata;
                        count_reg <= WAIT_INIT;
                        if (WAIT_STATES > 0) begin
                            state_reg <= S_WAIT;
                        end else begin
                            state_reg <= S_RESPOND;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_request) begin
                        state_reg <= S_IDLE;
                    end else if (count_reg > 4'd1) begin
                        count_reg <= count_reg - 4'd1;
                    end else begin
                        state_reg <= S_RESPOND;
                        ready_reg <= 1'b1;
                    end
                end
                S_RESPOND: state_reg <= S_IDLE;
                default:   state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (access_en && access_we) begin
            mem[access_idx] <= access_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rdata_reg <= 32'd0;
        end else if (access_en && !access_we) begin
            rdata_reg <= mem[access_idx];
        end
    end

    assign o_ready = ready_reg;
    assign o_rdata = rdata_reg;
endmodule

// File: tb/tb_cpu_bus_ram_target.sv
// Scoreboard bench for cpu_bus_ram_target: one 2-wait-state instance and one zero-wait instance.
module tb_cpu_bus_ram_target;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;
    logic        req_a, req_b, ready_a, ready_b;
    logic [31:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    assign req_a = req && (sel == 0);
    assign req_b = req && (sel == 1);

    cpu_bus_ram_target #(.SIZE(1024), .ADDR_LSH(2), .WAIT_STATES(2)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_request(req_a), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata_a), .o_ready(ready_a)
    );

    cpu_bus_ram_target #(.SIZE(1024), .ADDR_LSH(2), .WAIT_STATES(0)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_request(req_b), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata_b), .o_ready(ready_b)
    );

    typedef struct {
        int          cyc;
        int          dut;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] model [int];
    logic [31:0] last_rd [2];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction from an IDLE cycle; returns in the o_ready cycle.
    task automatic txn(input logic t_rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] alt_addr, input logic hold);
        int   ws;
        int   key;
        exp_t e;
        logic got;
        ws    = (sel == 0) ? 2 : 0;
        key   = sel * 4096 + int'((a >> 2) & 32'd1023);
        e.cyc = cyc + 1 + ws;
        e.dut = sel;
        if (t_rw) begin
            e.data     = last_rd[sel];
            model[key] = wd;
        end else begin
            e.data       = model[key];
            last_rd[sel] = e.data;
        end
        sb.push_back(e);
        $display("txn dut=%0d %s addr=%h wdata=%h expect ready@%0d data=%h",
                 sel, t_rw ? "WR" : "RD", a, wd, e.cyc, e.data);
        req = 1'b1; rw = t_rw; addr = a; wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle_cycle();
            if (i == 0) addr = alt_addr;
            if ((sel == 0 && ready_a) || (sel == 1 && ready_b)) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        if (!hold) req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ready_a || ready_b) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_cycle", cyc, mon_e.cyc);
                check("ready_dut", ready_b ? 32'd1 : 32'd0, mon_e.dut);
                check("rdata", ready_b ? rdata_b : rdata_a, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; rst = 1'b1; req = 1'b1; rw = 1'b1; addr = 32'h10; wdata = 32'h0BAD0BAD;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        // T1: reset held with a pending request
        repeat (2) idle_cycle();
        rst = 1'b0; req = 1'b0;
        check("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        repeat (3) idle_cycle();

        // T2: write then read with 2 wait states
        txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 1'b0); idle_cycle();
        txn(1'b0, 32'h10, 32'h0, 32'h10, 1'b0);        idle_cycle();

        // T3: back-to-back reads with request held through the ready cycle
        txn(1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0);   idle_cycle();
        txn(1'b1, 32'h4, 32'h22222222, 32'h4, 1'b0);   idle_cycle();
        txn(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);          idle_cycle();
        txn(1'b0, 32'h4, 32'h0, 32'h4, 1'b1);          idle_cycle();
        req = 1'b0;
        idle_cycle();

        // T4: address changed during WAIT must be ignored
        txn(1'b1, 32'h20, 32'h20202020, 32'h20, 1'b0); idle_cycle();
        txn(1'b0, 32'h10, 32'h0, 32'h20, 1'b0);        idle_cycle();

        // T5: abort during WAIT leaves memory untouched
        txn(1'b1, 32'h8, 32'hCAFE0008, 32'h8, 1'b0);   idle_cycle();
        req = 1'b1; rw = 1'b1; addr = 32'h8; wdata = 32'h12345678;
        idle_cycle();
        req = 1'b0;
        repeat (4) idle_cycle();
        txn(1'b0, 32'h8, 32'h0, 32'h8, 1'b0);          idle_cycle();

        // T6: zero wait states and address aliasing
        sel = 1;
        txn(1'b1, 32'h1000, 32'hA5A5A5A5, 32'h1000, 1'b0); idle_cycle();
        txn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);              idle_cycle();
        txn(1'b0, 32'h1000, 32'h0, 32'h1000, 1'b1);        idle_cycle();
        txn(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);              idle_cycle();

        // Reset during WAIT drops the pending write
        sel = 0;
        txn(1'b1, 32'h30, 32'h30303030, 32'h30, 1'b0); idle_cycle();
        req = 1'b1; rw = 1'b1; addr = 32'h30; wdata = 32'h00000BAD;
        idle_cycle();
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0; req = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        check("midrst_ready", {31'd0, ready_a}, 32'd0);
        check("midrst_rdata", rdata_a, 32'd0);
        repeat (4) idle_cycle();
        txn(1'b0, 32'h30, 32'h0, 32'h30, 1'b0);        idle_cycle();

        repeat (5) idle_cycle();
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
